// File: rtl/sdr_pkg.sv
// Shared types, constants and decode helpers for the SDRAM device responder.
package sdr_pkg;

    localparam int unsigned SDR_DW = 16;
    localparam int unsigned SDR_BW = SDR_DW / 8;
    localparam int unsigned ROW_AW = 4;
    localparam int unsigned COL_AW = 6;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned NBANK  = 4;
    localparam int unsigned ARR_AW = BA_W + ROW_AW + COL_AW;

    // {ras_n, cas_n, we_n} with cs_n low; cs_n high or cke low maps to NOP
    typedef enum logic [3:0] {
        CMD_LOAD_MODE    = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_ACTIVE       = 4'b0011,
        CMD_WRITE        = 4'b0100,
        CMD_READ         = 4'b0101,
        CMD_BURST_TERM   = 4'b0110,
        CMD_NOP          = 4'b0111
    } sdr_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR
    } burst_state_e;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_CLOSED    = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN  = 3'd2;
    localparam logic [2:0] ERR_MODE_BUSY = 3'd3;
    localparam logic [2:0] ERR_REF_OPEN  = 3'd4;

    // One read word travelling down the CAS-latency delay line
    typedef struct packed {
        logic              valid;
        logic [SDR_DW-1:0] data;
    } rd_word_t;

    function automatic sdr_cmd_e cmd_decode(input logic cke, input logic cs_n,
                                            input logic ras_n, input logic cas_n,
                                            input logic we_n);
        if (!cke || cs_n) return CMD_NOP;
        return sdr_cmd_e'({1'b0, ras_n, cas_n, we_n});
    endfunction

    function automatic logic [3:0] bl_decode(input logic [2:0] code);
        case (code)
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    // Only code 2 selects CL2; everything else runs at CL3
    function automatic logic cl3_decode(input logic [2:0] code);
        return code != 3'd2;
    endfunction

    // Sequential column advance, wrapping inside the aligned burst block
    function automatic logic [COL_AW-1:0] col_step(input logic [COL_AW-1:0] col,
                                                   input logic [3:0] bl);
        logic [COL_AW-1:0] wrap;
        wrap = COL_AW'(bl - 4'd1);
        return (col & ~wrap) | ((col + COL_AW'(1)) & wrap);
    endfunction

endpackage

// File: rtl/sdr_ram_rdpipe.sv
// Read-data delay line: CL2/CL3 alignment, 2-cycle read DQM, flush on write.
module sdr_ram_rdpipe
    import sdr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cl3,
    input  logic              flush,
    input  rd_word_t          in_word,
    input  logic [SDR_BW-1:0] dqm,
    output logic [SDR_DW-1:0] dq_out,
    output logic [SDR_BW-1:0] dq_oe
);

    rd_word_t          stage2;
    rd_word_t          out_word_c;
    logic [SDR_BW-1:0] dqm_d1;
    logic [SDR_BW-1:0] dqm_d2;

    // CL3 inserts one extra stage ahead of the output register
    always_comb begin
        out_word_c = cl3 ? stage2 : in_word;
    end

    // Delay stages, DQM shift and registered pad outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage2 <= '0;
            dqm_d1 <= '0;
            dqm_d2 <= '0;
            dq_out <= '0;
            dq_oe  <= '0;
        end else begin
            dqm_d1 <= dqm;
            dqm_d2 <= dqm_d1;
            dq_out <= out_word_c.data;
            if (flush) begin
                stage2 <= '0;
                dq_oe  <= '0;
            end else begin
                stage2 <= in_word;
                dq_oe  <= out_word_c.valid ? ~dqm_d2 : '0;
            end
        end
    end

endmodule

// File: rtl/sdr_ram_model.sv
// SDRAM device responder: command decode, bank tracking, burst engine, array.
module sdr_ram_model
    import sdr_pkg::*;
(
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              sdr_cke,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [BA_W-1:0]   sdr_ba,
    input  logic [ADDR_W-1:0] sdr_addr,
    input  logic [SDR_BW-1:0] sdr_dqm,
    input  logic [SDR_DW-1:0] sdr_dq_in,
    output logic [SDR_DW-1:0] sdr_dq_out,
    output logic [SDR_BW-1:0] sdr_dq_oe,
    output logic              sdr_err,
    output logic [2:0]        sdr_err_code
);

    localparam int unsigned DEPTH = 1 << ARR_AW;

    burst_state_e                  state, state_next;
    logic [BA_W-1:0]               b_bank, b_bank_next;
    logic [ROW_AW-1:0]             b_row, b_row_next;
    logic [COL_AW-1:0]             b_col, b_col_next;
    logic [3:0]                    b_left, b_left_next;
    logic                          b_ap, b_ap_next;
    logic [NBANK-1:0]              bank_open, bank_open_next;
    logic [NBANK-1:0][ROW_AW-1:0]  open_row, open_row_next;
    logic [3:0]                    mode_bl, mode_bl_next;
    logic                          mode_cl3, mode_cl3_next;
    logic                          err_next;
    logic [2:0]                    err_code_next;

    sdr_cmd_e                      cmd_c;
    logic                          start_c;
    logic                          kill_c;
    logic                          issue_rd_c;
    logic                          issue_wr_c;
    logic                          wr_cmd_c;
    logic [ARR_AW-1:0]             issue_addr_c;

    logic [SDR_DW-1:0]             mem [DEPTH];
    logic [SDR_DW-1:0]             rd_data;
    logic                          rd_valid;
    rd_word_t                      pipe_in_c;

    logic                          unused_addr;
    assign unused_addr = ^{sdr_addr[12:11], sdr_addr[9:7]};

    // Command decode, bank/mode updates and burst sequencing
    always_comb begin
        state_next     = state;
        b_bank_next    = b_bank;
        b_row_next     = b_row;
        b_col_next     = b_col;
        b_left_next    = b_left;
        b_ap_next      = b_ap;
        bank_open_next = bank_open;
        open_row_next  = open_row;
        mode_bl_next   = mode_bl;
        mode_cl3_next  = mode_cl3;
        err_next       = 1'b0;
        err_code_next  = ERR_NONE;
        start_c        = 1'b0;
        kill_c         = 1'b0;
        issue_rd_c     = 1'b0;
        issue_wr_c     = 1'b0;
        wr_cmd_c       = 1'b0;
        issue_addr_c   = {b_bank, b_row, b_col};

        cmd_c = cmd_decode(sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);

        case (cmd_c)
            CMD_LOAD_MODE: begin
                if ((|bank_open) || state != ST_IDLE) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_MODE_BUSY;
                end else begin
                    mode_bl_next  = bl_decode(sdr_addr[2:0]);
                    mode_cl3_next = cl3_decode(sdr_addr[6:4]);
                end
            end
            CMD_AUTO_REFRESH: begin
                if (|bank_open) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_REF_OPEN;
                end
            end
            CMD_PRECHARGE: begin
                if (sdr_addr[10]) bank_open_next = '0;
                else              bank_open_next[sdr_ba] = 1'b0;
                kill_c = (state != ST_IDLE) && (sdr_addr[10] || sdr_ba == b_bank);
            end
            CMD_ACTIVE: begin
                if (bank_open[sdr_ba]) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_ACT_OPEN;
                end else begin
                    bank_open_next[sdr_ba] = 1'b1;
                    open_row_next[sdr_ba]  = sdr_addr[ROW_AW-1:0];
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!bank_open[sdr_ba]) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_CLOSED;
                end else begin
                    start_c = 1'b1;
                end
            end
            CMD_BURST_TERM: kill_c = 1'b1;
            default: ;
        endcase

        // A new burst overrides termination and continuation on the same edge
        if (start_c) begin
            issue_addr_c = {sdr_ba, open_row[sdr_ba], sdr_addr[COL_AW-1:0]};
            issue_rd_c   = (cmd_c == CMD_READ);
            issue_wr_c   = (cmd_c == CMD_WRITE);
            wr_cmd_c     = (cmd_c == CMD_WRITE);
            b_bank_next  = sdr_ba;
            b_row_next   = open_row[sdr_ba];
            b_col_next   = col_step(sdr_addr[COL_AW-1:0], mode_bl);
            b_left_next  = mode_bl - 4'd1;
            b_ap_next    = sdr_addr[10];
            if (mode_bl == 4'd1) begin
                state_next = ST_IDLE;
                if (sdr_addr[10]) bank_open_next[sdr_ba] = 1'b0;
            end else begin
                state_next = (cmd_c == CMD_READ) ? ST_RD : ST_WR;
            end
        end else if (kill_c) begin
            state_next = ST_IDLE;
        end else if (state != ST_IDLE) begin
            issue_rd_c  = (state == ST_RD);
            issue_wr_c  = (state == ST_WR);
            b_col_next  = col_step(b_col, mode_bl);
            b_left_next = b_left - 4'd1;
            if (b_left == 4'd1) begin
                state_next = ST_IDLE;
                if (b_ap) bank_open_next[b_bank] = 1'b0;
            end
        end
    end

    // Burst state register
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) state <= ST_IDLE;
        else             state <= state_next;
    end

    // Burst context, bank table, mode register, error pulse and read valid
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            b_bank       <= '0;
            b_row        <= '0;
            b_col        <= '0;
            b_left       <= '0;
            b_ap         <= 1'b0;
            bank_open    <= '0;
            open_row     <= '0;
            mode_bl      <= 4'd1;
            mode_cl3     <= 1'b0;
            sdr_err      <= 1'b0;
            sdr_err_code <= ERR_NONE;
            rd_valid     <= 1'b0;
        end else begin
            b_bank       <= b_bank_next;
            b_row        <= b_row_next;
            b_col        <= b_col_next;
            b_left       <= b_left_next;
            b_ap         <= b_ap_next;
            bank_open    <= bank_open_next;
            open_row     <= open_row_next;
            mode_bl      <= mode_bl_next;
            mode_cl3     <= mode_cl3_next;
            sdr_err      <= err_next;
            sdr_err_code <= err_code_next;
            rd_valid     <= issue_rd_c;
        end
    end

    // Byte-masked array write and registered array read
    always_ff @(posedge sdram_clk) begin
        for (int b = 0; b < SDR_BW; b++) begin
            if (issue_wr_c && !sdr_dqm[b]) mem[issue_addr_c][b*8 +: 8] <= sdr_dq_in[b*8 +: 8];
        end
        rd_data <= mem[issue_addr_c];
    end

    // Word entering the latency pipe
    always_comb begin
        pipe_in_c.valid = rd_valid;
        pipe_in_c.data  = rd_data;
    end

    sdr_ram_rdpipe u_rdpipe (
        .clk     (sdram_clk),
        .rst     (sdram_reset),
        .cl3     (mode_cl3),
        .flush   (wr_cmd_c),
        .in_word (pipe_in_c),
        .dqm     (sdr_dqm),
        .dq_out  (sdr_dq_out),
        .dq_oe   (sdr_dq_oe)
    );

endmodule

// File: tb/tb_sdr_ram_model.sv
// Scoreboard bench for sdr_ram_model: expected read words and error pulses
// are queued with their observation cycle and compared on the falling edge.
module tb_sdr_ram_model;

    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_BST  = 4'b0110;
    localparam logic [3:0] C_NOP  = 4'b0111;

    logic        sdram_clk;
    logic        sdram_reset;
    logic        sdr_cke;
    logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]  sdr_ba;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_dqm;
    logic [15:0] sdr_dq_in;
    logic [15:0] sdr_dq_out;
    logic [1:0]  sdr_dq_oe;
    logic        sdr_err;
    logic [2:0]  sdr_err_code;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [1:0]  oe;
    } rd_exp_t;

    typedef struct {
        int         cyc;
        logic [2:0] code;
    } err_exp_t;

    rd_exp_t     rd_q[$];
    err_exp_t    err_q[$];
    logic [15:0] ref_mem [4096];
    int          row_of [4];
    logic [15:0] wd [8];
    logic [1:0]  wm [8];
    int          bl = 1;
    int          cl = 2;
    int          cyc = 0;
    int          last_n = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    sdr_ram_model dut (
        .sdram_clk    (sdram_clk),
        .sdram_reset  (sdram_reset),
        .sdr_cke      (sdr_cke),
        .sdr_cs_n     (sdr_cs_n),
        .sdr_ras_n    (sdr_ras_n),
        .sdr_cas_n    (sdr_cas_n),
        .sdr_we_n     (sdr_we_n),
        .sdr_ba       (sdr_ba),
        .sdr_addr     (sdr_addr),
        .sdr_dqm      (sdr_dqm),
        .sdr_dq_in    (sdr_dq_in),
        .sdr_dq_out   (sdr_dq_out),
        .sdr_dq_oe    (sdr_dq_oe),
        .sdr_err      (sdr_err),
        .sdr_err_code (sdr_err_code)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    always @(posedge sdram_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bmask(input logic [1:0] oe);
        return {{8{oe[1]}}, {8{oe[0]}}};
    endfunction

    function automatic int maddr(input int ba, input int row, input int col);
        return ba * 1024 + row * 64 + col;
    endfunction

    function automatic int colk(input int col, input int k);
        int m;
        m = bl - 1;
        return (col & ~m) | ((col + k) & m);
    endfunction

    // Compare outputs against the scoreboard heads every falling edge
    always @(negedge sdram_clk) begin
        rd_exp_t  re;
        err_exp_t ee;
        if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
            re = rd_q.pop_front();
            check("rd_oe", 32'(sdr_dq_oe), 32'(re.oe));
            check("rd_data", 32'(sdr_dq_out & bmask(re.oe)), 32'(re.data & bmask(re.oe)));
        end else begin
            check("idle_oe", 32'(sdr_dq_oe), 32'd0);
        end
        if (err_q.size() != 0 && err_q[0].cyc == cyc) begin
            ee = err_q.pop_front();
            check("err", 32'(sdr_err), 32'd1);
            check("err_code", 32'(sdr_err_code), 32'(ee.code));
        end else begin
            check("no_err", 32'(sdr_err), 32'd0);
        end
    end

    // Present one command for the next rising edge; last_n is that edge
    task automatic drive(input logic [3:0] c, input int ba, input int a,
                         input logic [15:0] d, input logic [1:0] m);
        @(negedge sdram_clk);
        sdr_cke = 1'b1;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
        sdr_ba    = 2'(ba);
        sdr_addr  = 13'(a);
        sdr_dq_in = d;
        sdr_dqm   = m;
        last_n    = cyc + 1;
    endtask

    task automatic nop(input int n);
        repeat (n) drive(C_NOP, 0, 0, 16'h0, 2'b00);
    endtask

    task automatic load_mode(input int blc, input int clc);
        drive(C_LMR, 0, (clc << 4) | blc, 16'h0, 2'b00);
        case (blc)
            1:       bl = 2;
            2:       bl = 4;
            3:       bl = 8;
            default: bl = 1;
        endcase
        cl = (clc == 2) ? 2 : 3;
    endtask

    task automatic activate(input int ba, input int row);
        drive(C_ACT, ba, row, 16'h0, 2'b00);
        row_of[ba] = row;
    endtask

    task automatic precharge_all();
        drive(C_PRE, 0, 13'h400, 16'h0, 2'b00);
    endtask

    task automatic err_cmd(input logic [3:0] c, input int ba, input int a, input logic [2:0] code);
        err_exp_t e;
        drive(c, ba, a, 16'h0, 2'b00);
        if (code != 3'd0) begin
            e.cyc  = last_n;
            e.code = code;
            err_q.push_back(e);
        end
    endtask

    // Full write burst from wd/wm; reference array updated per unmasked byte
    task automatic wr(input int ba, input int col);
        int a;
        for (int k = 0; k < bl; k++) begin
            if (k == 0) drive(C_WR, ba, col, wd[0], wm[0]);
            else        drive(C_NOP, 0, 0, wd[k], wm[k]);
            a = maddr(ba, row_of[ba], colk(col, k));
            for (int b = 0; b < 2; b++) begin
                if (!wm[k][b]) ref_mem[a][b*8 +: 8] = wd[k][b*8 +: 8];
            end
        end
    endtask

    // READ command; nwords words expected from cycle N+CL-1 onward
    task automatic rd(input int ba, input int col, input bit ap, input int nwords, input logic [1:0] m);
        rd_exp_t e;
        drive(C_RD, ba, col | (ap ? 32'h400 : 32'h0), 16'h0, m);
        for (int k = 0; k < nwords; k++) begin
            e.cyc  = last_n + cl - 1 + k;
            e.data = ref_mem[maddr(ba, row_of[ba], colk(col, k))];
            e.oe   = 2'b11;
            rd_q.push_back(e);
        end
    endtask

    initial begin
        sdram_reset = 1'b1;
        sdr_cke     = 1'b1;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = C_NOP;
        sdr_ba    = '0;
        sdr_addr  = '0;
        sdr_dqm   = '0;
        sdr_dq_in = '0;
        for (int k = 0; k < 8; k++) begin
            wd[k] = 16'h0;
            wm[k] = 2'b00;
        end

        repeat (3) @(negedge sdram_clk);
        check("rst_dq_out", 32'(sdr_dq_out), 32'd0);
        check("rst_dq_oe", 32'(sdr_dq_oe), 32'd0);
        check("rst_err", 32'(sdr_err), 32'd0);
        check("rst_err_code", 32'(sdr_err_code), 32'd0);
        sdram_reset = 1'b0;
        nop(2);

        // BL4 CL2 write then read back
        load_mode(2, 2);
        activate(0, 3);
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        wr(0, 0);
        rd(0, 0, 0, 4, 2'b00);
        nop(6);

        // CL3, read wraps inside the aligned block
        precharge_all();
        load_mode(2, 3);
        activate(0, 3);
        wd[0] = 16'hA4A4; wd[1] = 16'hA5A5; wd[2] = 16'hA6A6; wd[3] = 16'hA7A7;
        wr(0, 4);
        rd(0, 6, 0, 4, 2'b00);
        nop(7);

        // Write DQM masks the low byte of word 1
        wd[0] = 16'h5555; wd[1] = 16'h6666; wd[2] = 16'h7777; wd[3] = 16'h8888;
        wr(0, 8);
        wd[0] = 16'h9999; wd[1] = 16'hAAAA; wd[2] = 16'hBBBB; wd[3] = 16'hCCCC;
        wm[1] = 2'b01;
        wr(0, 8);
        wm[1] = 2'b00;
        rd(0, 8, 0, 4, 2'b00);
        nop(7);

        // Protocol errors, then commands that must be ignored silently
        err_cmd(C_RD, 2, 0, 3'd1);
        nop(1);
        err_cmd(C_ACT, 0, 3, 3'd2);
        err_cmd(C_LMR, 0, 13'h021, 3'd3);
        err_cmd(C_REF, 0, 0, 3'd4);
        nop(1);
        @(negedge sdram_clk);
        sdr_cke = 1'b0;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = C_RD;
        sdr_ba   = 2'd2;
        sdr_addr = '0;
        err_cmd(4'b1101, 2, 0, 3'd0);
        nop(3);

        // Auto-precharge read closes the bank for the next READ
        precharge_all();
        load_mode(1, 2);
        activate(1, 5);
        wd[0] = 16'hD1D1; wd[1] = 16'hD2D2;
        wr(1, 0);
        rd(1, 0, 1, 2, 2'b00);
        nop(1);
        err_cmd(C_RD, 1, 0, 3'd1);
        nop(4);

        // Back-to-back READs: second aborts the first, data gapless
        activate(1, 5);
        rd(1, 0, 0, 1, 2'b00);
        rd(1, 1, 0, 2, 2'b00);
        nop(5);

        // BL8 terminated after one word
        precharge_all();
        load_mode(3, 2);
        activate(0, 3);
        rd(0, 0, 0, 1, 2'b00);
        drive(C_BST, 0, 0, 16'h0, 2'b00);
        nop(10);

        // Read DQM on the READ edge blanks the high byte of word 1
        rd(0, 0, 0, 8, 2'b10);
        rd_q[rd_q.size() - 7].oe = 2'b01;
        nop(10);

        // WRITE two cycles into a read flushes the second word
        rd(0, 0, 0, 1, 2'b00);
        nop(1);
        for (int k = 0; k < 8; k++) wd[k] = 16'(16'hE000 + 16'(k * 16'h0111));
        wr(0, 16);
        rd(0, 16, 0, 8, 2'b00);
        nop(10);

        // Reset during a burst drops oe at once
        rd(0, 16, 0, 2, 2'b00);
        nop(2);
        @(negedge sdram_clk);
        @(posedge sdram_clk);
        #1 sdram_reset = 1'b1;
        #1 check("rst_mid_oe", 32'(sdr_dq_oe), 32'd0);
        repeat (2) @(negedge sdram_clk);
        check("rst2_dq_out", 32'(sdr_dq_out), 32'd0);
        check("rst2_err_code", 32'(sdr_err_code), 32'd0);
        sdram_reset = 1'b0;
        err_cmd(C_RD, 0, 0, 3'd1);
        nop(4);

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
